ldst_unit: RTL

//  Load/store sequencer between execute and main memory in the counter-driven multi-cycle core.

---
 rtl/ldst_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ldst_unit.sv
// Load/store sequencer: forms base+sext(imm), checks alignment and range, issues one
// memory-stage access and returns load data to writeback.
module ldst_unit #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_LSB = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic [XLEN-1:0] i_base,
    input  logic [11:0]     i_imm,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [2:0]      o_mem_sup,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic            o_busy,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_done,
    output logic            o_fault,
    output logic [2:0]      o_dbg_state
);

    // Handshake: i_start is a one-cycle request taken only while o_busy=0 (and is_load or
    // is_store set); every accepted request ends with exactly one o_done pulse, and a new
    // i_start is accepted from the cycle after that pulse. Requests seen while busy are dropped.

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [XLEN-1:0] L_DEPTH = XLEN'(DEPTH);

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic            r_is_load;
    logic            r_is_store;
    logic [XLEN-1:0] r_base;
    logic [11:0]     r_imm;
    logic [XLEN-1:0] r_st_data;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_index;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_accept;
    logic [XLEN-1:0] w_ea;
    logic [XLEN-1:0] w_ea_index;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_kind_conflict;
    logic            w_fault;
    logic            w_in_access;

    assign w_accept = (r_state == S_IDLE) && i_start && (i_is_load || i_is_store);

    // Effective address wraps modulo 2^XLEN; the range check applies to the wrapped value.
    assign w_ea            = r_base + {{(XLEN-12){r_imm[11]}}, r_imm};
    assign w_ea_index      = w_ea >> ADDR_LSB;
    assign w_misaligned    = |w_ea[ADDR_LSB-1:0];
    assign w_out_of_range  = (w_ea_index >= L_DEPTH);
    assign w_kind_conflict = r_is_load && r_is_store;
    assign w_fault         = w_misaligned || w_out_of_range || w_kind_conflict;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_ADDR;
            S_ADDR:   w_next_state = w_fault ? S_FAULT : S_ACCESS;
            S_ACCESS: w_next_state = r_is_load ? S_WAIT : S_DONE;
            S_WAIT:   w_next_state = S_WB;
            S_WB:     w_next_state = S_IDLE;
            S_DONE:   w_next_state = S_IDLE;
            S_FAULT:  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_base     <= '0;
            r_imm      <= '0;
            r_st_data  <= '0;
            r_rd       <= '0;
            r_index    <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_is_load  <= i_is_load;
                r_is_store <= i_is_store;
                r_base     <= i_base;
                r_imm      <= i_imm;
                r_st_data  <= i_st_data;
                r_rd       <= i_rd;
            end
            if (r_state == S_ADDR) begin
                r_index <= w_ea_index;
            end
            // Memory read data is registered by the memory, so it is valid during WAIT.
            if (r_state == S_WAIT) begin
                r_wb_data <= i_mem_rdata;
                r_wb_rd   <= r_rd;
            end
        end
    end

    assign w_in_access = (r_state == S_ACCESS) && !i_rst;

    assign o_mem_sup   = w_in_access ? 3'b011 : 3'b000;
    assign o_mem_read  = w_in_access && r_is_load && !r_is_store;
    assign o_mem_write = w_in_access && r_is_store && !r_is_load;
    assign o_mem_addr  = (r_state == S_ACCESS) ? r_index : '0;
    assign o_mem_wdata = ((r_state == S_ACCESS) && r_is_store) ? r_st_data : '0;

    assign o_busy      = (r_state != S_IDLE);
    assign o_wb_valid  = (r_state == S_WB);
    assign o_wb_rd     = r_wb_rd;
    assign o_wb_data   = r_wb_data;
    assign o_done      = (r_state == S_WB) || (r_state == S_DONE) || (r_state == S_FAULT);
    assign o_fault     = (r_state == S_FAULT);
    assign o_dbg_state = r_state;

endmodule
